fixpoint_loop_sched: RTL

Clocked scheduler for the two-process feedback datapath c = b, b = (inc_en ? c + 1 : a). It breaks the zero-delay combinational loop into alternating registered evaluation steps. It iterates until the loop reaches a fixpoint or an iteration budget runs out, then reports converged or timeout. It sits in front of the loop datapath and replaces free-running combinational evaluation with deterministic, seed-independent sequencing.

---
 rtl/fixpoint_loop_sched_if.sv | 31 +++
 rtl/fixpoint_loop_sched.sv | 113 +++++++++++
 2 files changed

// File: rtl/fixpoint_loop_sched_if.sv
// Bundle of the scheduler's request, result and debug signals.
// The master drives the request side; the scheduler owns everything else.
interface fixpoint_loop_sched_if #(
  parameter int WIDTH  = 2,
  parameter int ITER_W = 4
);
  logic              start;
  logic [WIDTH-1:0]  a_in;
  logic              inc_en;
  logic              busy;
  logic              done;
  logic              converged;
  logic              timeout;
  logic [WIDTH-1:0]  b_out;
  logic [WIDTH-1:0]  c_out;
  logic [ITER_W-1:0] iter_cnt;
  logic [2:0]        state_dbg;

  // Request/response contract: start is a level, sampled only while busy == 0.
  // A run is acknowledged by busy rising on the next edge and ends with a single-cycle done pulse.
  // converged and timeout are valid from done until the next accepted start.
  modport master (
    output start, a_in, inc_en,
    input  busy, done, converged, timeout, b_out, c_out, iter_cnt, state_dbg
  );

  modport slave (
    input  start, a_in, inc_en,
    output busy, done, converged, timeout, b_out, c_out, iter_cnt, state_dbg
  );
endinterface

// File: rtl/fixpoint_loop_sched.sv
// Sequential scheduler for the loop c = b, b = inc_en ? c + 1 : a.
// Alternates registered c and b updates until a fixpoint is reached or the iteration budget runs out.
module fixpoint_loop_sched #(
  parameter int WIDTH    = 2,
  parameter int MAX_ITER = 8,
  parameter int ITER_W   = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  fixpoint_loop_sched_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_EVAL_C = 3'd2,
    S_EVAL_B = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state_q, state_n;
  logic [WIDTH-1:0]  a_q, a_n;
  logic              inc_q, inc_n;
  logic [WIDTH-1:0]  b_q, b_n;
  logic [WIDTH-1:0]  c_q, c_n;
  logic [ITER_W-1:0] iter_q, iter_n;
  logic              conv_q, conv_n;
  logic              tmo_q, tmo_n;
  logic [WIDTH-1:0]  b_next;

  // Feedback value the loop would settle b to from the current c.
  assign b_next = inc_q ? (c_q + WIDTH'(1)) : a_q;

  always_comb begin
    state_n = state_q;
    a_n     = a_q;
    inc_n   = inc_q;
    b_n     = b_q;
    c_n     = c_q;
    iter_n  = iter_q;
    conv_n  = conv_q;
    tmo_n   = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_n     = bus.a_in;
          inc_n   = bus.inc_en;
          conv_n  = 1'b0;
          tmo_n   = 1'b0;
          iter_n  = '0;
          state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        b_n     = a_q;
        state_n = S_EVAL_C;
      end
      S_EVAL_C: begin
        c_n     = b_q;
        state_n = S_EVAL_B;
      end
      S_EVAL_B: begin
        if (b_next == b_q) begin
          conv_n  = 1'b1;
          state_n = S_DONE;
        end else if (iter_q == ITER_W'(MAX_ITER - 1)) begin
          b_n     = b_next;
          iter_n  = ITER_W'(MAX_ITER);
          tmo_n   = 1'b1;
          state_n = S_DONE;
        end else begin
          b_n     = b_next;
          iter_n  = iter_q + ITER_W'(1);
          state_n = S_EVAL_C;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      inc_q   <= 1'b0;
      b_q     <= '0;
      c_q     <= '0;
      iter_q  <= '0;
      conv_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      a_q     <= a_n;
      inc_q   <= inc_n;
      b_q     <= b_n;
      c_q     <= c_n;
      iter_q  <= iter_n;
      conv_q  <= conv_n;
      tmo_q   <= tmo_n;
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.converged = conv_q;
  assign bus.timeout   = tmo_q;
  assign bus.b_out     = b_q;
  assign bus.c_out     = c_q;
  assign bus.iter_cnt  = iter_q;
  assign bus.state_dbg = state_q;

endmodule
